// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown sequencer: load, start/pause/resume, clear, per-second
// decrement with tens borrow and a timed end-of-count alarm.
module countdown_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw,
  input  logic       start_pb,
  input  logic       clear_pb,
  input  logic [3:0] load_ones,
  input  logic [3:0] load_tens,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t        state_reg;
  logic [3:0]    ones_reg;
  logic [3:0]    tens_reg;
  logic [PW-1:0] presc_reg;
  logic [AW-1:0] alarm_cnt_reg;
  logic          running_reg;
  logic          done_reg;
  logic          alarm_reg;

  logic [3:0]    load_raw     [2];
  logic [3:0]    load_clamped [2];
  logic          load_nonzero;
  logic [3:0]    dec_ones;
  logic [3:0]    dec_tens;
  logic          dec_zero;
  logic          counting;
  logic          tick;
  logic          to_idle;

  assign load_raw[0] = load_ones;
  assign load_raw[1] = load_tens;

  // Out-of-range BCD presets saturate to 9 rather than being rejected.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_clamp
      assign load_clamped[gi] = (load_raw[gi] > 4'd9) ? 4'd9 : load_raw[gi];
    end
  endgenerate

  assign load_nonzero = (load_clamped[0] != 4'd0) || (load_clamped[1] != 4'd0);

  always_comb begin
    dec_ones = ones_reg;
    dec_tens = tens_reg;
    if (ones_reg != 4'd0) begin
      dec_ones = ones_reg - 4'd1;
    end else if (tens_reg != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_reg - 4'd1;
    end
  end

  assign dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0);
  assign counting = (state_reg == ST_RUN) || (state_reg == ST_DONE);
  assign tick     = counting && (presc_reg == PW'(TICK_DIV - 1));
  assign to_idle  = clear_pb || ((state_reg == ST_DONE) && start_pb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ones_reg      <= 4'd0;
      tens_reg      <= 4'd0;
      presc_reg     <= '0;
      alarm_cnt_reg <= '0;
      running_reg   <= 1'b0;
      done_reg      <= 1'b0;
      alarm_reg     <= 1'b0;
    end else if (to_idle) begin
      state_reg     <= ST_IDLE;
      ones_reg      <= load_clamped[0];
      tens_reg      <= load_clamped[1];
      presc_reg     <= '0;
      alarm_cnt_reg <= '0;
      running_reg   <= 1'b0;
      done_reg      <= 1'b0;
      alarm_reg     <= 1'b0;
    end else begin
      if (counting) begin
        presc_reg <= tick ? '0 : presc_reg + PW'(1);
      end
      case (state_reg)
        ST_IDLE: begin
          ones_reg <= load_clamped[0];
          tens_reg <= load_clamped[1];
          if (start_pb && sw && load_nonzero) begin
            state_reg   <= ST_RUN;
            presc_reg   <= '0;
            running_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tick) begin
            ones_reg <= dec_ones;
            tens_reg <= dec_tens;
          end
          // Reaching 00 outranks a coincident pause request.
          if (tick && dec_zero) begin
            state_reg     <= ST_DONE;
            presc_reg     <= '0;
            alarm_cnt_reg <= '0;
            running_reg   <= 1'b0;
            done_reg      <= 1'b1;
            alarm_reg     <= 1'b1;
          end else if (start_pb || !sw) begin
            state_reg   <= ST_PAUSE;
            running_reg <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (start_pb && sw) begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          ones_reg <= 4'd0;
          tens_reg <= 4'd0;
          if (tick && alarm_reg) begin
            alarm_cnt_reg <= alarm_cnt_reg + AW'(1);
            if (alarm_cnt_reg == AW'(ALARM_SECS - 1)) begin
              alarm_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ones    = ones_reg;
  assign tens    = tens_reg;
  assign running = running_reg;
  assign done    = done_reg;
  assign alarm   = alarm_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a short tick (4 cycles) and a 2-tick alarm.
module tb_countdown_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sw;
  logic       start_pb;
  logic       clear_pb;
  logic [3:0] load_ones;
  logic [3:0] load_tens;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       running;
  logic       done;
  logic       alarm;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  countdown_ctrl #(
    .TICK_DIV  (4),
    .ALARM_SECS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .start_pb (start_pb),
    .clear_pb (clear_pb),
    .load_ones(load_ones),
    .load_tens(load_tens),
    .ones     (ones),
    .tens     (tens),
    .running  (running),
    .done     (done),
    .alarm    (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h (t=%0t)", tag, got, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_pb = 1'b1;
    step(1);
    start_pb = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_pb = 1'b1;
    step(1);
    clear_pb = 1'b0;
  endtask

  task automatic set_load(input logic [3:0] t, input logic [3:0] o);
    load_tens = t;
    load_ones = o;
    step(1);
  endtask

  function automatic logic [7:0] disp();
    return {tens, ones};
  endfunction

  initial begin
    int rem;
    logic [7:0] exp_disp;

    // Reset with arbitrary inputs active
    rst_n = 1'b0; sw = 1'b1; start_pb = 1'b1; clear_pb = 1'b0;
    load_ones = 4'hF; load_tens = 4'hF;
    step(2);
    check_eq("rst_disp", 32'(disp()), 32'h00);
    check_eq("rst_running", 32'(running), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_alarm", 32'(alarm), 0);
    start_pb = 1'b0;
    rst_n = 1'b1;

    // Full count from 12
    set_load(4'd1, 4'd2);
    check_eq("idle_load12", 32'(disp()), 32'h12);
    pulse_start();
    check_eq("run12_running", 32'(running), 1);
    check_eq("run12_disp", 32'(disp()), 32'h12);
    for (int c = 1; c <= 48; c++) begin
      step(1);
      rem = 12 - c / 4;
      exp_disp = {4'(rem / 10), 4'(rem % 10)};
      check_eq($sformatf("count_c%0d", c), 32'(disp()), 32'(exp_disp));
      if (c == 47) check_eq("pre_done_running", 32'(running), 1);
    end
    check_eq("done_flag", 32'(done), 1);
    check_eq("done_running", 32'(running), 0);
    check_eq("alarm_on", 32'(alarm), 1);
    step(7);
    check_eq("alarm_still_on", 32'(alarm), 1);
    step(1);
    check_eq("alarm_off", 32'(alarm), 0);
    check_eq("done_holds", 32'(done), 1);
    check_eq("done_disp", 32'(disp()), 32'h00);
    pulse_start();
    check_eq("done_to_idle", 32'(done), 0);
    check_eq("idle_shows12", 32'(disp()), 32'h12);

    // Borrow from 20
    set_load(4'd2, 4'd0);
    pulse_start();
    step(3);
    check_eq("borrow_hold20", 32'(disp()), 32'h20);
    step(1);
    check_eq("borrow_19", 32'(disp()), 32'h19);
    step(4);
    check_eq("borrow_18", 32'(disp()), 32'h18);
    pulse_clear();
    check_eq("clear_running", 32'(running), 0);
    check_eq("clear_disp", 32'(disp()), 32'h20);

    // Pause / resume from 05
    set_load(4'd0, 4'd5);
    pulse_start();
    step(5);
    check_eq("pr_04", 32'(disp()), 32'h04);
    pulse_start();
    check_eq("pr_paused", 32'(running), 0);
    step(20);
    check_eq("pr_hold04", 32'(disp()), 32'h04);
    check_eq("pr_hold_running", 32'(running), 0);
    pulse_start();
    check_eq("pr_resumed", 32'(running), 1);
    step(1);
    check_eq("pr_still04", 32'(disp()), 32'h04);
    step(1);
    check_eq("pr_03", 32'(disp()), 32'h03);
    sw = 1'b0;
    step(1);
    check_eq("sw_pause", 32'(running), 0);
    step(10);
    check_eq("sw_hold03", 32'(disp()), 32'h03);
    sw = 1'b1;
    step(2);
    check_eq("sw_no_autoresume", 32'(running), 0);
    start_pb = 1'b1; clear_pb = 1'b1;
    step(1);
    start_pb = 1'b0; clear_pb = 1'b0;
    check_eq("clr_start_idle_run", 32'(running), 0);
    check_eq("clr_start_idle_disp", 32'(disp()), 32'h05);

    // start_pb on the final tick
    set_load(4'd0, 4'd1);
    pulse_start();
    step(3);
    pulse_start();
    check_eq("final_done", 32'(done), 1);
    check_eq("final_running", 32'(running), 0);
    check_eq("final_disp", 32'(disp()), 32'h00);
    pulse_start();
    check_eq("final_idle", 32'(disp()), 32'h01);

    // start_pb on a non-final tick
    set_load(4'd0, 4'd3);
    pulse_start();
    step(3);
    pulse_start();
    check_eq("nonfinal_disp", 32'(disp()), 32'h02);
    check_eq("nonfinal_running", 32'(running), 0);
    check_eq("nonfinal_done", 32'(done), 0);
    step(8);
    check_eq("nonfinal_hold", 32'(disp()), 32'h02);
    pulse_clear();

    // Load 00 + start stays idle
    set_load(4'd0, 4'd0);
    pulse_start();
    check_eq("zero_load_run", 32'(running), 0);
    step(8);
    check_eq("zero_load_done", 32'(done), 0);

    // Clamp of out-of-range presets
    set_load(4'hC, 4'hF);
    check_eq("clamp_99", 32'(disp()), 32'h99);
    pulse_start();
    step(3);
    check_eq("clamp_hold99", 32'(disp()), 32'h99);
    step(1);
    check_eq("clamp_98", 32'(disp()), 32'h98);
    pulse_clear();

    // Start with sw=0 is ignored
    sw = 1'b0;
    set_load(4'd0, 4'd5);
    pulse_start();
    check_eq("sw0_start", 32'(running), 0);
    step(4);
    check_eq("sw0_disp", 32'(disp()), 32'h05);
    sw = 1'b1;

    // Reset mid-run
    pulse_start();
    check_eq("rr_running", 32'(running), 1);
    step(5);
    check_eq("rr_04", 32'(disp()), 32'h04);
    rst_n = 1'b0;
    step(1);
    check_eq("rr_disp", 32'(disp()), 32'h00);
    check_eq("rr_running0", 32'(running), 0);
    check_eq("rr_done0", 32'(done), 0);
    check_eq("rr_alarm0", 32'(alarm), 0);
    rst_n = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencing controller for the two-digit BCD countdown timer (ones digit + tens digit, 00..99).
- Owns load, start/pause/resume, clear, per-second decrement with correct digit borrow, and end-of-count alarm.
- Sits between the debounced pushbutton/switch inputs and the 7-segment display driver; replaces ad-hoc decrement on a divided clock with a single-clock, tick-enabled FSM.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick; valid range >= 2.
- ALARM_SECS, 5, number of ticks alarm stays asserted after reaching 00; valid range >= 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- sw  input  1  arm switch; 1 = counting permitted.
- start_pb  input  1  debounced single-cycle pulse: start / pause / resume.
- clear_pb  input  1  debounced single-cycle pulse: abort to IDLE.
- load_ones  input  4  preset ones digit (BCD).
- load_tens  input  4  preset tens digit (BCD).
- ones  output  4  current ones digit.
- tens  output  4  current tens digit.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- alarm  output  1  high for the first ALARM_SECS ticks of DONE.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; ones=0, tens=0, running=0, done=0, alarm=0, prescaler=0, alarm counter=0. Reset wins over every other input in any state.
- Load clamp: any load digit > 9 is treated as 9.
- Prescaler: counts 0..TICK_DIV-1 only in RUN and DONE. tick=1 on the cycle prescaler==TICK_DIV-1; it then wraps to 0. Held (not cleared) in PAUSE; cleared on entry to RUN from IDLE and on entry to DONE.
- Priority each cycle: rst_n > clear_pb > tick-driven transitions > start_pb > sw.
- IDLE:
  - ones/tens follow the clamped load inputs every cycle.
  - start_pb && sw && load != 00 -> RUN.
  - start_pb with sw=0 or load == 00 -> ignored.
- RUN (running=1):
  - Tick decrement: if ones>0 then ones-1; else if tens>0 then ones=9, tens-1.
  - If the decrement produces 00 -> DONE on the same edge, even if start_pb is also asserted.
  - Otherwise start_pb -> PAUSE, with the tick decrement still applied if coincident.
  - sw=0 -> PAUSE.
  - clear_pb -> IDLE.
- PAUSE:
  - Digits and prescaler held.
  - start_pb && sw -> RUN, resuming from the held prescaler value.
  - clear_pb -> IDLE.
- DONE (done=1):
  - Digits = 00.
  - alarm=1 from entry until ALARM_SECS ticks have elapsed, then 0.
  - start_pb or clear_pb -> IDLE; alarm drops the same edge.
  - sw ignored.
- No underflow: digits never decrement below 00; never wrap to 99.
- Outputs are registered; running, done and alarm are valid the cycle after the state transition edge.

Test Plan (TICK_DIV=4, ALARM_SECS=2):
- Reset: assert rst_n=0 for 2 cycles with arbitrary inputs -> ones=0, tens=0, running=0, done=0, alarm=0.
- Full count: load 1,2 (=12), sw=1, pulse start_pb -> running=1; display steps 11,10,09,...,00 once every 4 cycles; done=1 at 00, 48 cycles after start; alarm high exactly 8 cycles, then low while done stays 1; start_pb -> IDLE showing 12.
- Borrow: load 20, start -> after 4 cycles shows 19, after 8 cycles shows 18; tens never shows 0xF, ones never shows 0xA.
- Pause/resume: load 05, start; 6 cycles later pulse start_pb -> shows 04, holds 20 cycles; pulse start_pb -> 03 appears after 2 more cycles (prescaler resumed). Separately, drop sw mid-RUN -> PAUSE, digits held.
- Simultaneous events:
  - clear_pb and start_pb in the same cycle in PAUSE -> IDLE.
  - start_pb on the tick that reaches 00 (load 01) -> DONE, not PAUSE.
  - start_pb on a non-final tick (load 03) -> 02 and PAUSE.
- Edge inputs:
  - load 00 + start -> stays IDLE.
  - load_ones=0xF, load_tens=0xC -> displays 99 and counts 98 next.
  - start with sw=0 -> ignored.
  - rst_n=0 mid-RUN -> all outputs 0 next edge.
